// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master and the existing SPI slave:
// command encodings, frame sizes and the master frame state enum.
`timescale 1ns/1ps
package spi_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_TX_BITS = 10;
    localparam int FRAME_RX_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEL    = 3'd1,
        DECIDE = 3'd2,
        SHIFT  = 3'd3,
        TURN   = 3'd4,
        RECV   = 3'd5,
        GAP    = 3'd6
    } spi_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Left-shifting register with parallel load; serial out is the MSB.
`timescale 1ns/1ps
module spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             sin,
    output logic             sout,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift_en) begin
            data <= {data[WIDTH-2:0], sin};
        end
    end

    assign sout = data[WIDTH-1];

endmodule

// File: rtl/spi_master.sv
// SPI initiator: turns one {cmd, wdata} request into an ss_n/MOSI frame and,
// for RD_DATA frames, collects the returned byte from MISO into rdata.
`timescale 1ns/1ps
module spi_master
    import spi_pkg::*;
#(
    parameter int TA_CYCLES  = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    input  logic       MISO,
    output logic       ss_n,
    output logic       MOSI,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic [2:0] dbg_state
);

    localparam int WAIT_W = $clog2(max2(TA_CYCLES, GAP_CYCLES) + 1);
    localparam logic [WAIT_W-1:0] TA_LOAD  = WAIT_W'(TA_CYCLES - 1);
    localparam logic [WAIT_W-1:0] GAP_LOAD = WAIT_W'(GAP_CYCLES - 1);
    localparam logic [3:0] TX_LAST = 4'(FRAME_TX_BITS - 1);
    localparam logic [3:0] RX_LAST = 4'(FRAME_RX_BITS - 1);

    spi_state_t        state, state_nxt;
    logic [3:0]        bit_cnt, bit_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              rd_frame;
    logic              accept;
    logic              tx_msb;
    logic [9:0]        tx_data;
    logic              rx_sout;
    logic [7:0]        rx_data;
    logic              unused_bits;

    // Handshake: start is taken only while busy=0 (IDLE); it is neither
    // queued nor remembered, and busy stays high until the last GAP cycle.
    assign accept = (state == IDLE) && start;

    spi_shift_reg #(.WIDTH(FRAME_TX_BITS)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data ({cmd, wdata}),
        .shift_en  (state == SHIFT),
        .sin       (1'b0),
        .sout      (tx_msb),
        .data      (tx_data)
    );

    spi_shift_reg #(.WIDTH(FRAME_RX_BITS)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (state == RECV),
        .sin       (MISO),
        .sout      (rx_sout),
        .data      (rx_data)
    );

    assign unused_bits = ^{tx_data, rx_data[7], rx_sout};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            rd_frame <= 1'b0;
            rdata    <= 8'h00;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                rd_frame <= (cmd == CMD_RD_DATA);
            end
            // The final MISO bit is folded in directly so rdata is whole on GAP entry.
            if (state == RECV && bit_cnt == 4'd0) begin
                rdata <= {rx_data[6:0], MISO};
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        wait_cnt_nxt = wait_cnt;
        ss_n         = 1'b1;
        MOSI         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SEL;
            end
            SEL: begin
                ss_n      = 1'b0;
                state_nxt = DECIDE;
            end
            DECIDE: begin
                ss_n        = 1'b0;
                MOSI        = tx_msb;
                state_nxt   = SHIFT;
                bit_cnt_nxt = TX_LAST;
            end
            SHIFT: begin
                ss_n = 1'b0;
                MOSI = tx_msb;
                if (bit_cnt == 4'd0) begin
                    state_nxt    = rd_frame ? TURN : GAP;
                    wait_cnt_nxt = rd_frame ? TA_LOAD : GAP_LOAD;
                end else begin
                    bit_cnt_nxt = bit_cnt - 4'd1;
                end
            end
            TURN: begin
                ss_n = 1'b0;
                if (wait_cnt == '0) begin
                    state_nxt   = RECV;
                    bit_cnt_nxt = RX_LAST;
                end else begin
                    wait_cnt_nxt = wait_cnt - WAIT_W'(1);
                end
            end
            RECV: begin
                ss_n = 1'b0;
                if (bit_cnt == 4'd0) begin
                    state_nxt    = GAP;
                    wait_cnt_nxt = GAP_LOAD;
                end else begin
                    bit_cnt_nxt = bit_cnt - 4'd1;
                end
            end
            GAP: begin
                if (wait_cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - WAIT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with TA_CYCLES=1, GAP_CYCLES=1: frame shapes,
// read capture, start filtering, mid-frame reset and a slave loopback model.
`timescale 1ns/1ps
module tb_spi_master;
    import spi_pkg::*;

    localparam int TA       = 1;
    localparam int GAP_C    = 1;
    localparam int MAXC     = 40;
    localparam int RX_FIRST = 13 + TA;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       MISO;
    logic       ss_n;
    logic       MOSI;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic [2:0] dbg_state;

    int errors = 0;
    int checks = 0;

    logic obs_ssn  [0:MAXC];
    logic obs_mosi [0:MAXC];
    logic obs_busy [0:MAXC];
    logic obs_done [0:MAXC];
    int         done_cycle;
    logic [7:0] rdata_at_done;

    logic [7:0] slave_mem [0:255];
    logic [7:0] s_wr_addr;
    logic [7:0] s_rd_addr;

    spi_master #(.TA_CYCLES(TA), .GAP_CYCLES(GAP_C)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cmd       (cmd),
        .wdata     (wdata),
        .MISO      (MISO),
        .ss_n      (ss_n),
        .MOSI      (MOSI),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int cnt_ssn_low();
        int n = 0;
        for (int k = 1; k <= MAXC; k++) if (obs_ssn[k] === 1'b0) n++;
        return n;
    endfunction

    function automatic int cnt_busy();
        int n = 0;
        for (int k = 1; k <= MAXC; k++) if (obs_busy[k] === 1'b1) n++;
        return n;
    endfunction

    function automatic int cnt_done();
        int n = 0;
        for (int k = 1; k <= MAXC; k++) if (obs_done[k] === 1'b1) n++;
        return n;
    endfunction

    // DECIDE bit followed by the ten SHIFT bits.
    function automatic logic [10:0] mosi_word();
        logic [10:0] w = '0;
        for (int k = 2; k <= 12; k++) w = {w[9:0], obs_mosi[k]};
        return w;
    endfunction

    // Issues one frame and records outputs for cycles 1..MAXC after acceptance.
    task automatic run_frame(input logic [1:0] c, input logic [7:0] d,
                             input logic [7:0] miso_byte, input int pulse_k);
        @(negedge clk);
        cmd = c; wdata = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cmd   = 2'($urandom_range(0, 3));
        wdata = 8'($urandom_range(0, 255));
        done_cycle = -1;
        rdata_at_done = 8'h00;
        for (int k = 1; k <= MAXC; k++) begin
            if (k >= RX_FIRST && k < RX_FIRST + 8) MISO = miso_byte[7 - (k - RX_FIRST)];
            else MISO = 1'($urandom_range(0, 1));
            if (k == pulse_k) begin
                start = 1'b1; cmd = CMD_RD_DATA; wdata = 8'hFF;
            end else begin
                start = 1'b0;
            end
            obs_ssn[k]  = ss_n;
            obs_mosi[k] = MOSI;
            obs_busy[k] = busy;
            obs_done[k] = done;
            if (done === 1'b1 && done_cycle < 0) begin
                done_cycle = k;
                rdata_at_done = rdata;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic slave_absorb();
        logic [10:0] w;
        w = mosi_word();
        case (w[9:8])
            CMD_WR_ADDR: s_wr_addr = w[7:0];
            CMD_WR_DATA: slave_mem[s_wr_addr] = w[7:0];
            CMD_RD_ADDR: s_rd_addr = w[7:0];
            default: ;
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cmd = 2'b00; wdata = 8'h00; MISO = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ss_n !== 1'b1) $display("FAIL reset_ss_n: got %b expected 1", ss_n);
        if (ss_n !== 1'b1) errors++;
        checks++; if (MOSI !== 1'b0) begin $display("FAIL reset_mosi: got %b expected 0", MOSI); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", busy); errors++; end
        checks++; if (done !== 1'b0) begin $display("FAIL reset_done: got %b expected 0", done); errors++; end
        checks++; if (rdata !== 8'h00) begin $display("FAIL reset_rdata: got %h expected 00", rdata); errors++; end
        checks++; if (dbg_state !== 3'd0) begin $display("FAIL reset_state: got %0d expected 0", dbg_state); errors++; end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wr_addr();
        run_frame(CMD_WR_ADDR, 8'h01, 8'h00, 0);
        checks++; if (obs_mosi[1] !== 1'b0) begin $display("FAIL wa_sel_mosi: got %b expected 0", obs_mosi[1]); errors++; end
        checks++; if (mosi_word() !== 11'b000_0000_0001) begin $display("FAIL wa_mosi: got %b expected 00000000001", mosi_word()); errors++; end
        checks++; if (cnt_ssn_low() != 12) begin $display("FAIL wa_ssn_len: got %0d expected 12", cnt_ssn_low()); errors++; end
        checks++; if (obs_ssn[13] !== 1'b1) begin $display("FAIL wa_gap_ssn: got %b expected 1", obs_ssn[13]); errors++; end
        checks++; if (done_cycle != 13) begin $display("FAIL wa_done_cycle: got %0d expected 13", done_cycle); errors++; end
        checks++; if (cnt_done() != 1) begin $display("FAIL wa_done_count: got %0d expected 1", cnt_done()); errors++; end
        checks++; if (cnt_busy() != 13) begin $display("FAIL wa_busy_len: got %0d expected 13", cnt_busy()); errors++; end
        checks++; if (obs_busy[14] !== 1'b0) begin $display("FAIL wa_busy_end: got %b expected 0", obs_busy[14]); errors++; end
    endtask

    task automatic test_wr_data();
        run_frame(CMD_WR_DATA, 8'hF1, 8'h00, 0);
        checks++; if (mosi_word() !== 11'b001_1111_0001) begin $display("FAIL wd_mosi: got %b expected 00111110001", mosi_word()); errors++; end
        checks++; if (done_cycle != 13) begin $display("FAIL wd_done_cycle: got %0d expected 13", done_cycle); errors++; end
        checks++; if (cnt_busy() != 13) begin $display("FAIL wd_busy_len: got %0d expected 13", cnt_busy()); errors++; end
        checks++; if (rdata !== 8'h00) begin $display("FAIL wd_rdata: got %h expected 00", rdata); errors++; end
    endtask

    task automatic test_rd_data();
        run_frame(CMD_RD_DATA, 8'h00, 8'hA5, 0);
        checks++; if (mosi_word() !== 11'b111_0000_0000) begin $display("FAIL rd_mosi: got %b expected 11100000000", mosi_word()); errors++; end
        checks++; if (cnt_ssn_low() != 21) begin $display("FAIL rd_ssn_len: got %0d expected 21", cnt_ssn_low()); errors++; end
        checks++; if (done_cycle != 22) begin $display("FAIL rd_done_cycle: got %0d expected 22", done_cycle); errors++; end
        checks++; if (cnt_busy() != 22) begin $display("FAIL rd_busy_len: got %0d expected 22", cnt_busy()); errors++; end
        checks++; if (rdata_at_done !== 8'hA5) begin $display("FAIL rd_rdata_at_done: got %h expected a5", rdata_at_done); errors++; end
        checks++; if (rdata !== 8'hA5) begin $display("FAIL rd_rdata_hold: got %h expected a5", rdata); errors++; end
    endtask

    task automatic test_rd_addr();
        run_frame(CMD_RD_ADDR, 8'h3C, 8'h5A, 0);
        checks++; if (mosi_word() !== 11'b110_0011_1100) begin $display("FAIL ra_mosi: got %b expected 11000111100", mosi_word()); errors++; end
        checks++; if (done_cycle != 13) begin $display("FAIL ra_done_cycle: got %0d expected 13", done_cycle); errors++; end
        checks++; if (rdata !== 8'hA5) begin $display("FAIL ra_rdata_kept: got %h expected a5", rdata); errors++; end
    endtask

    task automatic test_start_mid_shift();
        run_frame(CMD_WR_ADDR, 8'h96, 8'h00, 6);
        checks++; if (mosi_word() !== 11'b000_1001_0110) begin $display("FAIL ms_mosi: got %b expected 00010010110", mosi_word()); errors++; end
        checks++; if (done_cycle != 13) begin $display("FAIL ms_done_cycle: got %0d expected 13", done_cycle); errors++; end
        checks++; if (cnt_busy() != 13) begin $display("FAIL ms_busy_len: got %0d expected 13", cnt_busy()); errors++; end
        checks++; if (obs_busy[15] !== 1'b0) begin $display("FAIL ms_not_queued: got %b expected 0", obs_busy[15]); errors++; end
    endtask

    task automatic test_back_to_back();
        int first_done;
        int second_done;
        @(negedge clk);
        cmd = CMD_WR_DATA; wdata = 8'h5A; start = 1'b1;
        @(posedge clk); #1;
        first_done = -1;
        second_done = -1;
        for (int k = 1; k <= 28; k++) begin
            MISO = 1'($urandom_range(0, 1));
            obs_busy[k] = busy;
            obs_ssn[k]  = ss_n;
            if (done === 1'b1) begin
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
            if (k == 28) start = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (first_done != 13) begin $display("FAIL b2b_first_done: got %0d expected 13", first_done); errors++; end
        checks++; if (second_done != 27) begin $display("FAIL b2b_second_done: got %0d expected 27", second_done); errors++; end
        checks++; if (obs_busy[13] !== 1'b1) begin $display("FAIL b2b_busy_at_done: got %b expected 1", obs_busy[13]); errors++; end
        checks++; if (obs_busy[14] !== 1'b0) begin $display("FAIL b2b_idle_gap: got %b expected 0", obs_busy[14]); errors++; end
        checks++; if (obs_busy[15] !== 1'b1) begin $display("FAIL b2b_restart_busy: got %b expected 1", obs_busy[15]); errors++; end
        checks++; if (obs_ssn[15] !== 1'b0) begin $display("FAIL b2b_restart_ssn: got %b expected 0", obs_ssn[15]); errors++; end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        cmd = CMD_WR_DATA; wdata = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1 || ss_n !== 1'b0) begin $display("FAIL mr_in_frame: got busy=%b ss_n=%b expected busy=1 ss_n=0", busy, ss_n); errors++; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (ss_n !== 1'b1) begin $display("FAIL mr_ss_n: got %b expected 1", ss_n); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL mr_busy: got %b expected 0", busy); errors++; end
        checks++; if (MOSI !== 1'b0) begin $display("FAIL mr_mosi: got %b expected 0", MOSI); errors++; end
        checks++; if (rdata !== 8'h00) begin $display("FAIL mr_rdata: got %h expected 00", rdata); errors++; end
        run_frame(CMD_WR_ADDR, 8'h42, 8'h00, 0);
        checks++; if (mosi_word() !== 11'b000_0100_0010) begin $display("FAIL mr_next_mosi: got %b expected 00001000010", mosi_word()); errors++; end
        checks++; if (done_cycle != 13) begin $display("FAIL mr_next_done: got %0d expected 13", done_cycle); errors++; end
        checks++; if (cnt_busy() != 13) begin $display("FAIL mr_next_busy: got %0d expected 13", cnt_busy()); errors++; end
    endtask

    task automatic test_loopback();
        for (int i = 0; i < 256; i++) slave_mem[i] = 8'h00;
        s_wr_addr = 8'h00;
        s_rd_addr = 8'h00;
        run_frame(CMD_WR_ADDR, 8'h01, 8'h00, 0);
        slave_absorb();
        run_frame(CMD_WR_DATA, 8'hF1, 8'h00, 0);
        slave_absorb();
        run_frame(CMD_RD_ADDR, 8'h01, 8'h00, 0);
        slave_absorb();
        run_frame(CMD_RD_DATA, 8'h00, slave_mem[s_rd_addr], 0);
        slave_absorb();
        checks++; if (slave_mem[1] !== 8'hF1) begin $display("FAIL lb_mem1: got %h expected f1", slave_mem[1]); errors++; end
        checks++; if (rdata_at_done !== 8'hF1) begin $display("FAIL lb_rdata_at_done: got %h expected f1", rdata_at_done); errors++; end
        checks++; if (rdata !== 8'hF1) begin $display("FAIL lb_rdata: got %h expected f1", rdata); errors++; end
        checks++; if (done_cycle != 22) begin $display("FAIL lb_done_cycle: got %0d expected 22", done_cycle); errors++; end
    endtask

    initial begin
        test_reset();
        test_wr_addr();
        test_wr_data();
        test_rd_data();
        test_rd_addr();
        test_start_mid_shift();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Initiator end of the SPI link served by SPI_Wrapper (SPI slave plus single-port RAM).
- Converts a host-side command request (cmd, 8-bit payload) into one complete ss_n/MOSI frame, MSB first.
- For read-data frames, captures the 8 bits the slave returns on MISO and presents them on rdata.
- Lives in the same clock domain as the slave: outputs change on posedge clk, and the slave samples them on the following posedge.

Parameters:
- TA_CYCLES, 1, turnaround cycles between the last MOSI bit and the first MISO sample in a read-data frame (1..4).
- GAP_CYCLES, 1, minimum ss_n-high cycles at the end of every frame (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a frame; accepted only when busy=0.
- cmd  input  2  frame type: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- wdata  input  8  payload (address or write data); don't-care bits for RD_DATA are still shifted.
- MISO  input  1  serial data from slave.
- ss_n  output  1  slave select, active low.
- MOSI  output  1  serial data to slave.
- busy  output  1  high from the cycle after start is accepted through the final GAP cycle.
- done  output  1  one-cycle pulse in the last GAP cycle.
- rdata  output  8  last word received; updated only by RD_DATA frames.

Behaviour:
- Reset, sync, rst=1 at posedge: ss_n=1, MOSI=0, busy=0, done=0, rdata=0x00, state=IDLE, counters cleared.
- Reset mid-frame: ss_n=1 on the same edge, and the frame is abandoned. rdata is cleared by reset, not by abandonment.
- FSM states: IDLE, SEL, DECIDE, SHIFT, TURN, RECV, GAP.
- IDLE: ss_n=1, MOSI=0. On start=1, latch {cmd, wdata} into a 10-bit shift register and go to SEL.
- SEL (1 cycle): ss_n=0, MOSI=0. Go to DECIDE.
- DECIDE (1 cycle): MOSI=cmd[1], the slave's read/write selector. Go to SHIFT.
- SHIFT (10 cycles): MOSI = shift register MSB, shifting left each cycle. Bit order is cmd[1], cmd[0], wdata[7..0].
  - After 10 bits: cmd=11 goes to TURN; otherwise go to GAP.
- TURN (TA_CYCLES cycles): ss_n=0, MOSI=0, MISO ignored.
- RECV (8 cycles): ss_n=0, MOSI=0. Shift MISO into an rx register, MSB first, sampled at posedge. Then go to GAP.
- GAP (GAP_CYCLES cycles): ss_n=1, MOSI=0.
  - Last GAP cycle: done=1.
  - If cmd=11, rdata loads the rx register on entry to GAP, so it is stable when done=1.
  - Next state is IDLE.
- Frame lengths, busy cycles with defaults: 13 for WR_ADDR, WR_DATA and RD_ADDR; 22 for RD_DATA.
- start while busy=1: ignored, not queued.
- start in the same cycle as done: ignored, because busy=1. The earliest accepted restart is the cycle after done.
- cmd and wdata may change after acceptance without affecting the frame in flight.
- Counters:
  - The bit counter is 4 bits and counts 9 down to 0 in SHIFT, and 7 down to 0 in RECV.
  - The wait counter is sized by $clog2(max(TA_CYCLES, GAP_CYCLES)+1).
  - No wrap is allowed: each state exits at count 0.
- MISO is don't-care outside RECV. X/Z on MISO in other states must not propagate to rdata.

Decomposition:
- Package spi_pkg holds:
  - cmd encodings CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - the state enum;
  - constants FRAME_TX_BITS=10 and FRAME_RX_BITS=8.
- The package is shared with the existing SPI slave.
- One sub-module is natural: spi_shift_reg, a parameterised-width shift register with load, shift_en, serial in and serial out, instantiated once for TX and once for RX.

Test Plan:
1. rst=1 for 2 cycles -> ss_n=1, MOSI=0, busy=0, done=0, rdata=0x00. Then cmd=00, wdata=0x01, start=1 for 1 cycle -> ss_n low 12 cycles; MOSI in DECIDE then SHIFT = 0, 0,0,0000_0001; done at cycle 13; busy high 13 cycles.
2. cmd=01, wdata=0xF1 -> MOSI in DECIDE then SHIFT = 0, 0,1,1111_0001; done at cycle 13; rdata unchanged.
3. cmd=11 with a MISO model driving 0xA5 MSB first in RECV -> ss_n low 21 cycles; rdata=0xA5 when done=1 at cycle 22.
4. start held high continuously -> new frames begin only the cycle after each done. Pulse start mid-SHIFT -> ignored, and the frame sequence is unaltered.
5. Assert rst during bit 5 of SHIFT -> ss_n=1 and busy=0 on that edge. A subsequent cmd=00 frame completes normally in 13 cycles.
6. Loopback to SPI_Wrapper: WR_ADDR 0x01, WR_DATA 0xF1, RD_ADDR 0x01, RD_DATA -> rdata=0xF1 and slave RAM mem[1]=0xF1.
